// File: rtl/fdiv_arbiter_pkg.sv
// Shared types and constants for the two-requester FP divider arbiter.
package fdiv_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Bit positions inside the 5-bit response flag vector
  localparam int FLAG_UNDERFLOW  = 0;
  localparam int FLAG_OVERFLOW   = 1;
  localparam int FLAG_DIVBYZERO  = 2;
  localparam int FLAG_ILLEGAL_OP = 3;
  localparam int FLAG_TIMEOUT    = 4;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  localparam int WDOG_W = 16;

  typedef struct packed {
    state_e            state;
    logic              rr;
    logic              owner;
    logic [63:0]       op_a;
    logic [63:0]       op_b;
    logic [63:0]       res;
    logic [4:0]        flags;
    logic [1:0]        resp_valid;
    logic [WDOG_W-1:0] wdog;
  } regs_t;

  localparam regs_t REGS_RST = '{
    state:      ST_IDLE,
    rr:         1'b0,
    owner:      1'b0,
    op_a:       64'd0,
    op_b:       64'd0,
    res:        64'd0,
    flags:      5'd0,
    resp_valid: 2'd0,
    wdog:       16'd0
  };

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/fdiv_arbiter.sv
// Round-robin arbiter sharing one FP divider between two requesters,
// with a WAIT watchdog that answers with a timeout qNaN if the divider stalls.
module fdiv_arbiter
  import fdiv_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [63:0] i_req_a0,
  input  logic [63:0] i_req_b0,
  input  logic [63:0] i_req_a1,
  input  logic [63:0] i_req_b1,
  output logic [1:0]  o_resp_valid,
  input  logic [1:0]  i_resp_ready,
  output logic [63:0] o_resp_res,
  output logic [4:0]  o_resp_flags,
  output logic        o_div_ena,
  output logic [63:0] o_div_a,
  output logic [63:0] o_div_b,
  input  logic [63:0] i_div_res,
  input  logic        i_div_illegal_op,
  input  logic        i_div_divbyzero,
  input  logic        i_div_overflow,
  input  logic        i_div_underflow,
  input  logic        i_div_valid,
  input  logic        i_div_busy
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  regs_t      r_q;
  regs_t      r_d;
  logic       gnt_idx_s;
  logic [1:0] req_ready_s;
  logic       div_ena_s;

  // Tie goes to the rr pointer; a lone requester wins regardless
  always_comb begin
    gnt_idx_s = 1'b0;
    if (i_req_valid == 2'b11) begin
      gnt_idx_s = r_q.rr;
    end else if (i_req_valid[1]) begin
      gnt_idx_s = 1'b1;
    end else begin
      gnt_idx_s = 1'b0;
    end
  end

  // Grant and issue strobes must act in the same cycle, so they stay combinational
  always_comb begin
    req_ready_s = 2'b00;
    div_ena_s   = 1'b0;
    if (!i_rst && (r_q.state == ST_IDLE) && (|i_req_valid)) begin
      req_ready_s = onehot2(gnt_idx_s);
    end else begin
      req_ready_s = 2'b00;
    end
    if (!i_rst && (r_q.state == ST_ISSUE) && !i_div_busy) begin
      div_ena_s = 1'b1;
    end else begin
      div_ena_s = 1'b0;
    end
  end

  // Next-state logic for the whole register set
  always_comb begin
    r_d = r_q;
    case (r_q.state)
      ST_IDLE: begin
        if (|i_req_valid) begin
          r_d.owner = gnt_idx_s;
          r_d.op_a  = gnt_idx_s ? i_req_a1 : i_req_a0;
          r_d.op_b  = gnt_idx_s ? i_req_b1 : i_req_b0;
          r_d.state = ST_ISSUE;
        end else begin
          r_d.state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!i_div_busy) begin
          r_d.wdog  = 16'd0;
          r_d.state = ST_WAIT;
        end else begin
          r_d.state = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A result arriving on the terminal watchdog cycle still wins
        if (i_div_valid) begin
          r_d.res                    = i_div_res;
          r_d.flags                  = 5'd0;
          r_d.flags[FLAG_ILLEGAL_OP] = i_div_illegal_op;
          r_d.flags[FLAG_DIVBYZERO]  = i_div_divbyzero;
          r_d.flags[FLAG_OVERFLOW]   = i_div_overflow;
          r_d.flags[FLAG_UNDERFLOW]  = i_div_underflow;
          r_d.resp_valid             = onehot2(r_q.owner);
          r_d.state                  = ST_HOLD;
        end else if (r_q.wdog == WDOG_LAST) begin
          r_d.res                 = QNAN;
          r_d.flags               = 5'd0;
          r_d.flags[FLAG_TIMEOUT] = 1'b1;
          r_d.resp_valid          = onehot2(r_q.owner);
          r_d.state               = ST_HOLD;
        end else begin
          r_d.wdog = r_q.wdog + 16'd1;
        end
      end
      ST_HOLD: begin
        if (i_resp_ready[r_q.owner]) begin
          r_d.resp_valid = 2'b00;
          r_d.rr         = ~r_q.owner;
          r_d.state      = ST_IDLE;
        end else begin
          r_d.state = ST_HOLD;
        end
      end
      default: begin
        r_d = REGS_RST;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= REGS_RST;
    end else begin
      r_q <= r_d;
    end
  end

  assign o_req_ready  = req_ready_s;
  assign o_div_ena    = div_ena_s;
  assign o_div_a      = r_q.op_a;
  assign o_div_b      = r_q.op_b;
  assign o_resp_valid = r_q.resp_valid;
  assign o_resp_res   = r_q.res;
  assign o_resp_flags = r_q.flags;

endmodule

// File: doc/fdiv_arbiter.md
FDIV_ARBITER -- requirements
Module: fdiv_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before the watchdog aborts an operation.
REQ-002 Port i_clk  in  1  CPU clock; all logic on its rising edge.
REQ-003 Port i_rst  in  1  reset, synchronous, active-high.
REQ-004 Ports i_req_valid  in  2, o_req_ready  out  2: per-requester request handshake; bit n = requester n.
REQ-005 Ports i_req_a0, i_req_b0, i_req_a1, i_req_b1  in  64 each: IEEE-754 double operands (dividend a, divisor b).
REQ-006 Ports o_resp_valid  out  2, i_resp_ready  in  2: per-requester response handshake.
REQ-007 Ports o_resp_res  out  64, o_resp_flags  out  5: result and {timeout, illegal_op, divbyzero, overflow, underflow}, shared by both requesters, qualified by o_resp_valid.
REQ-008 Ports o_div_ena  out  1, o_div_a  out  64, o_div_b  out  64: divider issue.
REQ-009 Ports i_div_res  in  64, i_div_illegal_op, i_div_divbyzero, i_div_overflow, i_div_underflow, i_div_valid, i_div_busy  in  1 each: divider completion and status.

Function
REQ-010 FSM states IDLE, ISSUE, WAIT, HOLD; exactly one operation in flight.
REQ-011 IDLE: if any i_req_valid is set, grant one requester, assert its o_req_ready in that cycle only, latch its operands and the owner index, and go to ISSUE; otherwise stay.
REQ-012 Arbitration is round-robin: rr pointer = 0 after reset; if both are valid, the pointer's requester wins; if only one is valid, it wins regardless of the pointer.
REQ-013 o_req_ready is 0 in ISSUE, WAIT and HOLD; at most one bit is high in any cycle.
REQ-014 ISSUE: when i_div_busy = 0, assert o_div_ena for exactly one cycle with o_div_a/o_div_b = latched operands, clear the watchdog, and go to WAIT; while i_div_busy = 1, stay and hold o_div_ena = 0.
REQ-015 o_div_a/o_div_b hold the latched operands in all states after the grant; they are 0 after reset.
REQ-016 WAIT: on i_div_valid, capture i_div_res and the four status bits with timeout = 0, and go to HOLD the next cycle.
REQ-017 WAIT watchdog: the counter increments each WAIT cycle; if it reaches TIMEOUT_CYCLES-1 without i_div_valid, go to HOLD with result 0x7FF8000000000000 and flags = 5'b10000.
REQ-018 If i_div_valid coincides with the watchdog terminal cycle, the divider result wins.
REQ-019 HOLD: drive o_resp_valid[owner] = 1 and keep o_resp_res/o_resp_flags stable; on i_resp_ready[owner], go to IDLE and set the rr pointer to ~owner.
REQ-020 i_resp_ready of the non-owner is ignored.
REQ-021 i_div_valid in IDLE, ISSUE or HOLD (stale result after a timeout) is ignored.
REQ-022 Minimum latency from grant to o_resp_valid = divider latency + 2 cycles; a new grant is possible no earlier than the cycle after the response handshake.

Reset
REQ-023 Reset values: state IDLE, rr pointer 0, watchdog 0, and o_req_ready, o_resp_valid, o_resp_res, o_resp_flags, o_div_ena, o_div_a, o_div_b all 0.
REQ-024 Reset asserted in any state, including mid-WAIT, returns the block to reset values on the next edge; any in-flight response is lost.

Structure
REQ-025 Package fdiv_arbiter_pkg holds the state enum, the flag bit-index constants, the canonical qNaN constant, the register struct and its reset value.
REQ-026 The block has no sub-module: the round-robin select and watchdog are inline; DoubleDiv is instantiated by the parent.

Verification
REQ-027 Req0 only, a = 0x4018000000000000, b = 0x4000000000000000 -> one o_div_ena pulse, then o_resp_valid = 2'b01, res = 0x4008000000000000, flags = 0.
REQ-028 Both requesters valid in the same cycle after reset -> req0 granted first and req1 granted in the first IDLE cycle after req0's response handshake.
REQ-029 Req1, a = 0x3FF0000000000000, b = 0 -> res = 0x7FF0000000000000, flags divbyzero = 1, response on bit 1.
REQ-030 Divider stub never asserts valid, TIMEOUT_CYCLES = 64 -> response 64 cycles after the WAIT entry, res = 0x7FF8000000000000, flags = 5'b10000; a late i_div_valid is ignored.
REQ-031 i_resp_ready held low 10 cycles in HOLD with req1 valid -> res and flags stable, o_req_ready = 0 throughout, and req1 granted only after the handshake.
REQ-032 i_rst pulsed during WAIT -> next cycle state IDLE and all outputs 0; the next request completes normally.
